// File: rtl/sensor_pwr_ctl.sv
// sensor_pwr_ctl: host-side initiator for the sensor power manager's enable/ready handshake.
// Turns the level request i_cfg_power_on into a supervised power-up/power-down sequence.
// Power-up timeout and loss of ready are retried after a cooldown. Once the retry budget is
// spent the block latches FAULT until i_fault_clear.
//
// Ports:
//   i_clk72          system clock
//   i_reset          asynchronous active-high reset
//   i_cfg_power_on   level request, 1 = sensor powered
//   i_cfg_pgood_en   PGOOD gating config, forwarded (registered) to o_mng_pgood_en
//   i_fault_clear    single-cycle pulse, clears fault code and retry count
//   o_mng_enable     power manager enable (UP and ON)
//   o_mng_pgood_en   power manager pgood_en
//   i_mng_ready      power manager ready (already in the clk72 domain)
//   o_sensor_active  sensor powered and ready
//   o_busy           sequencing in progress (UP, DOWN, COOL)
//   o_fault          FAULT latched
//   o_fault_code     0 none, 1 up-timeout, 2 ready-lost
//   o_retry_count    retries consumed
//   o_state          0 OFF, 1 UP, 2 ON, 3 DOWN, 4 COOL, 5 FAULT
module sensor_pwr_ctl #(
    parameter int unsigned PRESCL_DIV    = 72000,
    parameter int unsigned UP_TIMEOUT_MS = 16,
    parameter int unsigned DOWN_TIME_MS  = 4,
    parameter int unsigned COOLDOWN_MS   = 100,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic       i_clk72,
    input  logic       i_reset,
    input  logic       i_cfg_power_on,
    input  logic       i_cfg_pgood_en,
    input  logic       i_fault_clear,
    output logic       o_mng_enable,
    output logic       o_mng_pgood_en,
    input  logic       i_mng_ready,
    output logic       o_sensor_active,
    output logic       o_busy,
    output logic       o_fault,
    output logic [1:0] o_fault_code,
    output logic [3:0] o_retry_count,
    output logic [2:0] o_state
);

    localparam int unsigned PW = (PRESCL_DIV > 1) ? $clog2(PRESCL_DIV) : 1;
    localparam logic [PW-1:0] PRESCL_MAX = PW'(PRESCL_DIV - 1);
    localparam logic [15:0] UP_TO   = 16'(UP_TIMEOUT_MS);
    localparam logic [15:0] DOWN_TO = 16'(DOWN_TIME_MS);
    localparam logic [15:0] COOL_TO = 16'(COOLDOWN_MS);
    localparam logic [3:0]  RETRY_MAX = (MAX_RETRY > 15) ? 4'd15 : 4'(MAX_RETRY);
    localparam logic [1:0]  CODE_UP_TIMEOUT = 2'd1;
    localparam logic [1:0]  CODE_READY_LOST = 2'd2;

    typedef enum logic [2:0] {
        StOff   = 3'd0,
        StUp    = 3'd1,
        StOn    = 3'd2,
        StDown  = 3'd3,
        StCool  = 3'd4,
        StFault = 3'd5
    } state_e;

    state_e        r_state, w_state_d;
    logic [PW-1:0] r_prescl;
    logic          w_tick;
    logic [15:0]   r_timer;
    logic [1:0]    r_fault_code, w_fault_code_d;
    logic [3:0]    r_retry, w_retry_d;
    logic          w_fault_evt;
    logic [1:0]    w_evt_code;

    logic          r_mng_enable, r_mng_pgood_en, r_sensor_active, r_busy, r_fault;
    logic [2:0]    r_state_out;

    // Free-running ms prescaler
    assign w_tick = (r_prescl == PRESCL_MAX);

    always_ff @(posedge i_clk72 or posedge i_reset) begin
        if (i_reset) begin
            r_prescl <= '0;
        end else if (w_tick) begin
            r_prescl <= '0;
        end else begin
            r_prescl <= r_prescl + 1'b1;
        end
    end

    // ms timer: cleared on any state entry (wins over tick), saturating
    always_ff @(posedge i_clk72 or posedge i_reset) begin
        if (i_reset) begin
            r_timer <= '0;
        end else if (w_state_d != r_state) begin
            r_timer <= '0;
        end else if (w_tick && (r_timer != 16'hFFFF)) begin
            r_timer <= r_timer + 16'd1;
        end
    end

    // Next-state, fault code and retry count
    always_comb begin
        w_state_d      = r_state;
        w_fault_code_d = r_fault_code;
        w_retry_d      = r_retry;
        w_fault_evt    = 1'b0;
        w_evt_code     = 2'd0;

        if (i_fault_clear) begin
            w_fault_code_d = 2'd0;
            w_retry_d      = 4'd0;
        end

        case (r_state)
            StOff: begin
                if (i_cfg_power_on) w_state_d = StUp;
            end
            StUp: begin
                if (i_mng_ready) begin
                    w_state_d = StOn;
                end else if (!i_cfg_power_on) begin
                    w_state_d = StDown;
                end else if (r_timer >= UP_TO) begin
                    w_fault_evt = 1'b1;
                    w_evt_code  = CODE_UP_TIMEOUT;
                end
            end
            StOn: begin
                if (!i_cfg_power_on) begin
                    w_state_d = StDown;
                end else if (!i_mng_ready) begin
                    w_fault_evt = 1'b1;
                    w_evt_code  = CODE_READY_LOST;
                end
            end
            StDown: begin
                if ((r_timer >= DOWN_TO) && !i_mng_ready) begin
                    w_state_d = StOff;
                    w_retry_d = 4'd0;
                end
            end
            StCool: begin
                if ((r_timer >= COOL_TO) && !i_mng_ready) begin
                    w_state_d = i_cfg_power_on ? StUp : StOff;
                end
            end
            StFault: begin
                if (i_fault_clear) w_state_d = StOff;
            end
            default: w_state_d = StOff;
        endcase

        // A fault event overrides a coincident fault_clear
        if (w_fault_evt) begin
            w_fault_code_d = w_evt_code;
            if (r_retry < RETRY_MAX) begin
                w_retry_d = r_retry + 4'd1;
                w_state_d = StCool;
            end else begin
                w_retry_d = r_retry;
                w_state_d = StFault;
            end
        end
    end

    always_ff @(posedge i_clk72 or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= StOff;
            r_fault_code <= 2'd0;
            r_retry      <= 4'd0;
        end else begin
            r_state      <= w_state_d;
            r_fault_code <= w_fault_code_d;
            r_retry      <= w_retry_d;
        end
    end

    // Registered outputs, one cycle behind the state that drives them
    always_ff @(posedge i_clk72 or posedge i_reset) begin
        if (i_reset) begin
            r_mng_enable    <= 1'b0;
            r_mng_pgood_en  <= 1'b0;
            r_sensor_active <= 1'b0;
            r_busy          <= 1'b0;
            r_fault         <= 1'b0;
            r_state_out     <= 3'd0;
        end else begin
            r_mng_enable    <= (r_state == StUp) || (r_state == StOn);
            r_mng_pgood_en  <= i_cfg_pgood_en;
            r_sensor_active <= (r_state == StOn) && i_mng_ready;
            r_busy          <= (r_state == StUp) || (r_state == StDown) || (r_state == StCool);
            r_fault         <= (r_state == StFault);
            r_state_out     <= r_state;
        end
    end

    assign o_mng_enable    = r_mng_enable;
    assign o_mng_pgood_en  = r_mng_pgood_en;
    assign o_sensor_active = r_sensor_active;
    assign o_busy          = r_busy;
    assign o_fault         = r_fault;
    assign o_fault_code    = r_fault_code;
    assign o_retry_count   = r_retry;
    assign o_state         = r_state_out;

endmodule

// File: tb/tb_sensor_pwr_ctl.sv
// tb_sensor_pwr_ctl: directed sequence plus random soak for sensor_pwr_ctl, checked every cycle
// against a behavioural model of the sequencing rules kept in the bench.
module tb_sensor_pwr_ctl;

    localparam int PD   = 10;
    localparam int UPT  = 4;
    localparam int DNT  = 2;
    localparam int CLT  = 3;
    localparam int MAXR = 2;

    localparam int S_OFF = 0, S_UP = 1, S_ON = 2, S_DOWN = 3, S_COOL = 4, S_FAULT = 5;

    logic       clk72 = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_power_on = 1'b0;
    logic       cfg_pgood_en = 1'b0;
    logic       fault_clear = 1'b0;
    logic       mng_ready = 1'b0;
    logic       mng_enable, mng_pgood_en, sensor_active, busy, fault;
    logic [1:0] fault_code;
    logic [3:0] retry_count;
    logic [2:0] state;

    sensor_pwr_ctl #(
        .PRESCL_DIV   (PD),
        .UP_TIMEOUT_MS(UPT),
        .DOWN_TIME_MS (DNT),
        .COOLDOWN_MS  (CLT),
        .MAX_RETRY    (MAXR)
    ) dut (
        .i_clk72        (clk72),
        .i_reset        (reset),
        .i_cfg_power_on (cfg_power_on),
        .i_cfg_pgood_en (cfg_pgood_en),
        .i_fault_clear  (fault_clear),
        .o_mng_enable   (mng_enable),
        .o_mng_pgood_en (mng_pgood_en),
        .i_mng_ready    (mng_ready),
        .o_sensor_active(sensor_active),
        .o_busy         (busy),
        .o_fault        (fault),
        .o_fault_code   (fault_code),
        .o_retry_count  (retry_count),
        .o_state        (state)
    );

    always #5 clk72 = ~clk72;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: sequencer phase, ms elapsed in phase, edges since reset
    int m_state, m_ms, m_cyc, m_code, m_retry;
    int m_o_en, m_o_pg, m_o_act, m_o_busy, m_o_fault, m_o_state;
    int n_state, n_ms, n_code, n_retry;
    int n_o_en, n_o_pg, n_o_act, n_o_busy, n_o_fault, n_o_state;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = S_OFF; m_ms = 0; m_cyc = 0; m_code = 0; m_retry = 0;
        m_o_en = 0; m_o_pg = 0; m_o_act = 0; m_o_busy = 0; m_o_fault = 0; m_o_state = 0;
    endtask

    // Rules evaluated on the inputs present just before a clock edge
    task automatic model_calc();
        bit tick;
        bit fevt;
        int fcode;
        tick = ((m_cyc % PD) == PD - 1);
        fevt = 0;
        fcode = 0;
        n_o_en    = (m_state == S_UP || m_state == S_ON) ? 1 : 0;
        n_o_pg    = int'(cfg_pgood_en);
        n_o_act   = (m_state == S_ON && mng_ready) ? 1 : 0;
        n_o_busy  = (m_state == S_UP || m_state == S_DOWN || m_state == S_COOL) ? 1 : 0;
        n_o_fault = (m_state == S_FAULT) ? 1 : 0;
        n_o_state = m_state;
        n_state = m_state;
        n_code  = fault_clear ? 0 : m_code;
        n_retry = fault_clear ? 0 : m_retry;
        if (m_state == S_OFF) begin
            if (cfg_power_on) n_state = S_UP;
        end else if (m_state == S_UP) begin
            if (mng_ready) n_state = S_ON;
            else if (!cfg_power_on) n_state = S_DOWN;
            else if (m_ms >= UPT) begin fevt = 1; fcode = 1; end
        end else if (m_state == S_ON) begin
            if (!cfg_power_on) n_state = S_DOWN;
            else if (!mng_ready) begin fevt = 1; fcode = 2; end
        end else if (m_state == S_DOWN) begin
            if (m_ms >= DNT && !mng_ready) begin n_state = S_OFF; n_retry = 0; end
        end else if (m_state == S_COOL) begin
            if (m_ms >= CLT && !mng_ready) n_state = cfg_power_on ? S_UP : S_OFF;
        end else begin
            if (fault_clear) n_state = S_OFF;
        end
        if (fevt) begin
            n_code = fcode;
            if (m_retry < MAXR) begin n_retry = m_retry + 1; n_state = S_COOL; end
            else begin n_retry = m_retry; n_state = S_FAULT; end
        end
        if (n_state != m_state) n_ms = 0;
        else if (tick) n_ms = (m_ms < 65535) ? m_ms + 1 : 65535;
        else n_ms = m_ms;
    endtask

    task automatic model_apply();
        m_state = n_state; m_ms = n_ms; m_code = n_code; m_retry = n_retry; m_cyc++;
        m_o_en = n_o_en; m_o_pg = n_o_pg; m_o_act = n_o_act; m_o_busy = n_o_busy;
        m_o_fault = n_o_fault; m_o_state = n_o_state;
    endtask

    task automatic check_all();
        chk("mng_enable", 16'(mng_enable), 16'(m_o_en));
        chk("mng_pgood_en", 16'(mng_pgood_en), 16'(m_o_pg));
        chk("sensor_active", 16'(sensor_active), 16'(m_o_act));
        chk("busy", 16'(busy), 16'(m_o_busy));
        chk("fault", 16'(fault), 16'(m_o_fault));
        chk("fault_code", 16'(fault_code), 16'(m_code));
        chk("retry_count", 16'(retry_count), 16'(m_retry));
        chk("state", 16'(state), 16'(m_o_state));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_en"}, 16'(mng_enable), 16'd0);
        chk({tag, "_pg"}, 16'(mng_pgood_en), 16'd0);
        chk({tag, "_act"}, 16'(sensor_active), 16'd0);
        chk({tag, "_busy"}, 16'(busy), 16'd0);
        chk({tag, "_fault"}, 16'(fault), 16'd0);
        chk({tag, "_code"}, 16'(fault_code), 16'd0);
        chk({tag, "_retry"}, 16'(retry_count), 16'd0);
        chk({tag, "_state"}, 16'(state), 16'd0);
    endtask

    // One clock: model sees the same pre-edge inputs, outputs checked 1 time unit later
    task automatic cyc();
        model_calc();
        @(posedge clk72);
        model_apply();
        #1;
        check_all();
    endtask

    task automatic run_until(input int st, input int budget, input string tag);
        int n = 0;
        while (m_state != st && n < budget) begin
            cyc();
            n++;
        end
        cyc();
        chk(tag, 16'(state), 16'(st));
    endtask

    task automatic run_until_en(input int budget, input string tag);
        int n = 0;
        while (m_o_en == 0 && n < budget) begin
            cyc();
            n++;
        end
        chk(tag, 16'(mng_enable), 16'd1);
    endtask

    task automatic power_up_with_delay(input int dly, input string tag);
        run_until_en(20, {tag, "_en"});
        repeat (dly) cyc();
        mng_ready = 1'b1;
        run_until(S_ON, 20, {tag, "_on"});
    endtask

    initial begin
        int n;
        model_reset();
        // Reset state
        #2;
        check_zero("rst");
        repeat (2) @(posedge clk72);
        #3;
        reset = 1'b0;
        model_reset();
        cfg_pgood_en = 1'b1;

        // 1. Normal power-up, ready 20 cycles after enable
        cfg_power_on = 1'b1;
        power_up_with_delay(20, "pu");
        repeat (2) cyc();
        chk("pu_state", 16'(state), 16'(S_ON));
        chk("pu_active", 16'(sensor_active), 16'd1);
        chk("pu_busy", 16'(busy), 16'd0);
        chk("pu_code", 16'(fault_code), 16'd0);

        // 2. Power-down, ready drops 5 cycles later
        cfg_power_on = 1'b0;
        repeat (5) cyc();
        mng_ready = 1'b0;
        run_until(S_OFF, 100, "pd_off");
        chk("pd_retry", 16'(retry_count), 16'd0);
        chk("pd_en", 16'(mng_enable), 16'd0);

        // 3. Timeouts with retries, then FAULT
        cfg_power_on = 1'b1;
        run_until(S_FAULT, 600, "to_fault");
        cyc();
        chk("to_flag", 16'(fault), 16'd1);
        chk("to_code", 16'(fault_code), 16'd1);
        chk("to_retry", 16'(retry_count), 16'(MAXR));
        chk("to_en", 16'(mng_enable), 16'd0);

        // 4. Fault clear with power request still high
        fault_clear = 1'b1;
        cyc();
        fault_clear = 1'b0;
        chk("fc_code", 16'(fault_code), 16'd0);
        chk("fc_retry", 16'(retry_count), 16'd0);
        cyc();
        chk("fc_off", 16'(state), 16'(S_OFF));
        cyc();
        chk("fc_up", 16'(state), 16'(S_UP));

        // 5. Ready lost for one cycle while ON
        power_up_with_delay(int'($urandom_range(1, 25)), "rl");
        repeat (3) cyc();
        mng_ready = 1'b0;
        cyc();
        chk("rl_code", 16'(fault_code), 16'd2);
        chk("rl_retry", 16'(retry_count), 16'd1);
        chk("rl_active", 16'(sensor_active), 16'd0);
        mng_ready = 1'b1;
        cyc();
        mng_ready = 1'b0;
        cyc();
        chk("rl_cool", 16'(state), 16'(S_COOL));
        run_until(S_UP, 100, "rl_retry_up");
        power_up_with_delay(int'($urandom_range(1, 25)), "rl2");

        // 6a. ON: power-off request and ready drop together -> DOWN, code kept
        cfg_power_on = 1'b0;
        mng_ready = 1'b0;
        cyc();
        chk("pr_code", 16'(fault_code), 16'd2);
        cyc();
        chk("pr_down", 16'(state), 16'(S_DOWN));
        run_until(S_OFF, 100, "pr_off");

        // 6b. UP: ready arrives in the cycle the timeout is reached -> ON
        cfg_power_on = 1'b1;
        n = 0;
        while (!(m_state == S_UP && m_ms >= UPT) && n < 100) begin
            cyc();
            n++;
        end
        mng_ready = 1'b1;
        cyc();
        cyc();
        chk("pr_ready_wins", 16'(state), 16'(S_ON));
        chk("pr_no_retry", 16'(retry_count), 16'd0);
        cfg_power_on = 1'b0;
        repeat (3) cyc();
        mng_ready = 1'b0;
        run_until(S_OFF, 100, "pr_off2");

        // 6c. Async reset in the middle of UP
        cfg_power_on = 1'b1;
        run_until_en(20, "ar_en");
        #2;
        reset = 1'b1;
        #1;
        check_zero("ar");
        repeat (2) @(posedge clk72);
        #3;
        reset = 1'b0;
        model_reset();
        repeat (5) cyc();

        // Random soak against the model
        for (int i = 0; i < 600; i++) begin
            cfg_pgood_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) cfg_power_on = ~cfg_power_on;
            if (m_o_en != 0) begin
                if (!mng_ready && $urandom_range(0, 11) == 0) mng_ready = 1'b1;
                else if (mng_ready && $urandom_range(0, 149) == 0) mng_ready = 1'b0;
            end else if (mng_ready && $urandom_range(0, 3) == 0) begin
                mng_ready = 1'b0;
            end
            fault_clear = ($urandom_range(0, 79) == 0);
            cyc();
        end
        fault_clear = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
